vc_injector: RTL

VC_INJECTOR -- requirements
Module: vc_injector

---
 rtl/vc_injector.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/vc_injector.sv
// vc_injector: captures one word per virtual channel into a hold register and
// pushes held words downstream one per cycle under round-robin arbitration.
module vc_injector #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int BUF_WIDTH      = 3,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enb,
  input  logic                                    iniciar,
  input  logic [QUEUE_QUANTITY-1:0]               req,
  input  logic [QUEUE_QUANTITY*(BUF_WIDTH+1)-1:0] req_data,
  input  logic [QUEUE_QUANTITY-1:0]               pausa,
  input  logic [QUEUE_QUANTITY-1:0]               continuar,
  input  logic [QUEUE_QUANTITY-1:0]               error_full,
  output logic [QUEUE_QUANTITY-1:0]               ack,
  output logic                                    iniciar_out,
  output logic                                    push,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]       vc_id,
  output logic [BUF_WIDTH:0]                      data_word,
  output logic [QUEUE_QUANTITY-1:0]               paused,
  output logic [QUEUE_QUANTITY-1:0]               drop_err,
  output logic [CNT_WIDTH-1:0]                    sent_cnt,
  output logic                                    idle
);

  localparam int VC_W = $clog2(QUEUE_QUANTITY);
  localparam int DW   = BUF_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Handshakes: a source holds req[i] with its word until it sees ack[i]
  // (a one-cycle pulse after capture); push is a one-cycle valid strobe for
  // vc_id/data_word with no back-pressure from downstream.

  logic [1:0]                state_q, state_d;
  logic                      idle_q, idle_d;
  logic                      iniciar_out_q, iniciar_out_d;
  logic                      push_q, push_d;
  logic [QUEUE_QUANTITY-1:0] ack_q, ack_d;
  logic [VC_W-1:0]           vc_id_q, vc_id_d;
  logic [DW-1:0]             data_word_q, data_word_d;
  logic [QUEUE_QUANTITY-1:0] paused_q, paused_d;
  logic [QUEUE_QUANTITY-1:0] drop_err_q, drop_err_d;
  logic [CNT_WIDTH-1:0]      sent_cnt_q, sent_cnt_d;
  logic [QUEUE_QUANTITY-1:0] hold_vld_q, hold_vld_d;
  logic [DW-1:0]             hold_data_q [QUEUE_QUANTITY];
  logic [DW-1:0]             hold_data_d [QUEUE_QUANTITY];
  logic [VC_W-1:0]           ptr_q, ptr_d;

  logic [QUEUE_QUANTITY-1:0] eligible;
  logic                      grant_vld;
  logic [VC_W-1:0]           grant_idx;
  logic                      hi_vld, lo_vld;
  logic [VC_W-1:0]           hi_idx, lo_idx;
  logic                      start_run;

  assign eligible = hold_vld_q & ~paused_q & ~drop_err_q;

  // Round robin: lowest eligible index above the pointer, else lowest at or below it.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = QUEUE_QUANTITY - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (i > int'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = VC_W'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = VC_W'(i);
        end
      end
    end
    grant_vld = hi_vld | lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    paused_d    = paused_q;
    drop_err_d  = drop_err_q;
    sent_cnt_d  = sent_cnt_q;
    vc_id_d     = vc_id_q;
    data_word_d = data_word_q;
    push_d      = 1'b0;
    ack_d       = '0;
    start_run   = 1'b0;

    if (enb) begin
      case (state_q)
        ST_IDLE: begin
          if (iniciar) begin
            state_d   = ST_RUN;
            start_run = 1'b1;
          end
        end
        ST_RUN: begin
          if (!iniciar) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (iniciar) state_d = ST_RUN;
          else if (hold_vld_q == '0) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      // pausa dominates continuar when both arrive together.
      paused_d   = pausa | (paused_q & ~continuar);
      drop_err_d = (start_run ? '0 : drop_err_q) | error_full;

      if (grant_vld) begin
        push_d                = 1'b1;
        vc_id_d               = grant_idx;
        data_word_d           = hold_data_q[grant_idx];
        ptr_d                 = grant_idx;
        sent_cnt_d            = sent_cnt_q + 1'b1;
        hold_vld_d[grant_idx] = 1'b0;
      end

      // A hold emptied by this cycle's grant can refill in the same cycle.
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        if (state_q == ST_RUN && req[i] && !hold_vld_d[i] && !drop_err_d[i]) begin
          hold_vld_d[i]  = 1'b1;
          hold_data_d[i] = req_data[i*DW +: DW];
          ack_d[i]       = 1'b1;
        end
      end

      hold_vld_d = hold_vld_d & ~drop_err_d;
    end

    idle_d        = (state_d == ST_IDLE);
    iniciar_out_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      idle_q        <= 1'b1;
      iniciar_out_q <= 1'b0;
      push_q        <= 1'b0;
      ack_q         <= '0;
      vc_id_q       <= '0;
      data_word_q   <= '0;
      paused_q      <= '0;
      drop_err_q    <= '0;
      sent_cnt_q    <= '0;
      hold_vld_q    <= '0;
      ptr_q         <= VC_W'(QUEUE_QUANTITY - 1);
      for (int i = 0; i < QUEUE_QUANTITY; i++) hold_data_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      idle_q        <= idle_d;
      iniciar_out_q <= iniciar_out_d;
      push_q        <= push_d;
      ack_q         <= ack_d;
      vc_id_q       <= vc_id_d;
      data_word_q   <= data_word_d;
      paused_q      <= paused_d;
      drop_err_q    <= drop_err_d;
      sent_cnt_q    <= sent_cnt_d;
      hold_vld_q    <= hold_vld_d;
      ptr_q         <= ptr_d;
      hold_data_q   <= hold_data_d;
    end
  end

  assign ack         = ack_q;
  assign iniciar_out = iniciar_out_q;
  assign push        = push_q;
  assign vc_id       = vc_id_q;
  assign data_word   = data_word_q;
  assign paused      = paused_q;
  assign drop_err    = drop_err_q;
  assign sent_cnt    = sent_cnt_q;
  assign idle        = idle_q;

endmodule
